sqrt_interp_sequencer: RTL and testbench

Sequences one piecewise-linear square-root evaluation per request in the Box-Muller AWGN datapath.
- Takes the log-stage value x and derives a 64-entry segment address.
- Reads the slope/offset word from the external sqrt coefficient ROM, then evaluates y = C0 + ((C1 * frac) >> FRAC_W) over a multicycle FSM.
- Hands the result to the cos/sin multiply stage over a valid/ready handshake.
- One sample in flight at a time; not pipelined.

---
 rtl/sqrt_interp_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_sqrt_interp_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_interp_sequencer.sv
// sqrt_interp_sequencer
// Piecewise-linear square-root evaluator for the Box-Muller AWGN datapath.
// One request is processed at a time: the top ADDR_W bits of the log-stage
// value select a segment in the external coefficient ROM, the next FRAC_W
// bits interpolate along it, and the result y = C0 + ((C1 * frac) >> FRAC_W)
// is offered downstream on a valid/ready handshake.
//
// Build option: define SQRT_SAT_EN to clamp overflowing results to all ones
// and raise the sticky sat_flag. Without it the result wraps modulo 2^Y_W and
// sat_flag is tied low.
module sqrt_interp_sequencer #(
    parameter int X_W     = 24,
    parameter int ADDR_W  = 6,
    parameter int FRAC_W  = 12,
    parameter int Y_W     = 20,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [X_W-1:0]    in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Y_W-1:0]    out_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              busy,
    output logic              sat_flag
);

    // ROM word layout: slope in the upper 20 bits, offset in the lower 12.
    localparam int C1_W   = 20;
    localparam int C0_W   = 12;
    localparam int PROD_W = C1_W + FRAC_W;
    localparam int HI_W   = PROD_W - FRAC_W;
    localparam int CNT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_ADD  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [FRAC_W-1:0] r_frac;
    logic [C1_W-1:0]   r_c1;
    logic [C0_W-1:0]   r_c0;
    logic [PROD_W-1:0] r_prod;
    logic [Y_W-1:0]    r_out_y;
    logic              r_out_valid;

    logic [ADDR_W-1:0] w_addr;
    logic [FRAC_W-1:0] w_frac;
    logic              w_accept;
    logic              w_rom_cap;
    logic              w_do_mul;
    logic              w_do_add;
    logic              w_handshake;
    logic [HI_W-1:0]   w_prod_hi;
    logic [Y_W:0]      w_sum;
    logic [Y_W-1:0]    w_y;

`ifdef SQRT_SAT_EN
    // Clamp anything that does not fit in Y_W bits to the largest code.
    function automatic logic [Y_W-1:0] fit_y(input logic [Y_W:0] s);
        return s[Y_W] ? {Y_W{1'b1}} : s[Y_W-1:0];
    endfunction
`else
    // Plain modulo-2^Y_W result; the carry out is simply dropped.
    function automatic logic [Y_W-1:0] fit_y(input logic [Y_W-1:0] s);
        return s;
    endfunction
`endif

    // Segment address and interpolation fraction taken straight from in_x.
    assign w_addr = in_x[X_W-1 -: ADDR_W];
    assign w_frac = in_x[X_W-ADDR_W-1 -: FRAC_W];

    generate
        if (X_W > ADDR_W + FRAC_W) begin : g_lsb
            // Bits below the fraction carry no information for this stage.
            logic w_unused_lsb;
            assign w_unused_lsb = ^in_x[X_W-ADDR_W-FRAC_W-1:0];
        end
    endgenerate

    // Per-state strobes shared by the control and datapath blocks.
    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_rom_cap   = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_do_mul    = (r_state == S_MUL);
    assign w_do_add    = (r_state == S_ADD);
    assign w_handshake = (r_state == S_DONE) && out_ready;

    // Interpolation sum carries one spare bit so overflow is visible.
    assign w_prod_hi = r_prod[PROD_W-1:FRAC_W];
    assign w_sum     = (Y_W+1)'(r_c0) + (Y_W+1)'(w_prod_hi);

`ifdef SQRT_SAT_EN
    assign w_y = fit_y(w_sum);
`else
    logic w_unused_ovf;
    assign w_unused_ovf = w_sum[Y_W];
    assign w_y          = fit_y(w_sum[Y_W-1:0]);
`endif

    // Sequencer: IDLE -> WAIT (ROM_LAT cycles) -> MUL -> ADD -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= CNT_W'(ROM_LAT - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_rom_cap) begin
                        r_state <= S_MUL;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_MUL: begin
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath captures, each enabled by the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rom_addr <= '0;
            r_frac     <= '0;
            r_c1       <= '0;
            r_c0       <= '0;
            r_prod     <= '0;
            r_out_y    <= '0;
        end else begin
            if (w_accept) begin
                r_rom_addr <= w_addr;
                r_frac     <= w_frac;
            end
            if (w_rom_cap) begin
                r_c1 <= rom_data[31:12];
                r_c0 <= rom_data[11:0];
            end
            if (w_do_mul) begin
                r_prod <= PROD_W'(r_c1) * PROD_W'(r_frac);
            end
            if (w_do_add) begin
                r_out_y <= w_y;
            end
        end
    end

`ifdef SQRT_SAT_EN
    logic r_sat_flag;

    // Sticky overflow indication; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat_flag <= 1'b0;
        end else if (w_do_add && w_sum[Y_W]) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign sat_flag = r_sat_flag;
`else
    assign sat_flag = 1'b0;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign rom_addr  = r_rom_addr;

endmodule

// File: tb/tb_sqrt_interp_sequencer.sv
// Directed bench for sqrt_interp_sequencer. Two instances share clock and
// reset: one at the default ROM_LAT=1 behind a combinational ROM model, one at
// ROM_LAT=3 behind a ROM model that delays its data accordingly.
// ROM contents: entry 0 = {C1=300, C0=1087}, entry 5 = {C1=0xFFFFF, C0=0xFFF},
// entry 63 = {C1=513, C0=1054}, any other entry a = {C1=a*4096, C0=a}, so for
// those y = a + a*frac.
module tb_sqrt_interp_sequencer;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, out_valid, out_ready, busy, sat_flag;
    logic [23:0] in_x;
    logic [19:0] out_y;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data;

    logic        in_valid3, in_ready3, out_valid3, out_ready3, busy3, sat_flag3;
    logic [23:0] in_x3;
    logic [19:0] out_y3;
    logic [5:0]  rom_addr3;
    logic [31:0] rom_data3;
    logic [31:0] rom3_d1, rom3_d2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sqrt_interp_sequencer u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .busy(busy), .sat_flag(sat_flag)
    );

    sqrt_interp_sequencer #(.ROM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_x(in_x3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_y(out_y3),
        .rom_addr(rom_addr3), .rom_data(rom_data3),
        .busy(busy3), .sat_flag(sat_flag3)
    );

    function automatic logic [31:0] rom_word(input logic [5:0] a);
        case (a)
            6'd0:    return {20'd300, 12'd1087};
            6'd5:    return {20'hFFFFF, 12'hFFF};
            6'd63:   return {20'd513, 12'd1054};
            default: return {2'b00, a, 12'h000, 6'b000000, a};
        endcase
    endfunction

    // Latency-1 ROM: data follows the registered address within the cycle.
    always_comb rom_data = rom_word(rom_addr);

    // Latency-3 ROM: two extra register stages after the registered address.
    always @(posedge clk) begin
        rom3_d1 <= rom_word(rom_addr3);
        rom3_d2 <= rom3_d1;
    end
    assign rom_data3 = rom3_d2;

    // Present x for one accept edge, then wait at negedges for out_valid.
    // lat counts clock edges including the accept edge.
    task automatic accept_and_wait(input logic [23:0] x, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finish_handshake();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, sat_flag} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl: got ready/valid/busy/sat=%b required 1000",
                     {in_ready, out_valid, busy, sat_flag});
        end
        checks++;
        if (out_y !== 20'h0 || rom_addr !== 6'd0) begin
            failures++;
            $display("FAIL reset_data: got out_y=%h rom_addr=%0d required 0/0", out_y, rom_addr);
        end
        checks++;
        if ({in_ready3, out_valid3, busy3} !== 3'b100) begin
            failures++;
            $display("FAIL reset_lat3: got ready/valid/busy=%b required 100",
                     {in_ready3, out_valid3, busy3});
        end
        reset = 1'b0;
    endtask

    task automatic test_first_entry();
        int lat;
        accept_and_wait(24'h000000, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL first_latency: got %0d required 4", lat);
        end
        checks++;
        if (out_y !== 20'h0043F) begin
            failures++;
            $display("FAIL first_out_y: got %h required 0043f", out_y);
        end
        checks++;
        if ({rom_addr, in_ready, busy} !== {6'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL first_done_state: got addr=%0d ready=%b busy=%b required 0/0/1",
                     rom_addr, in_ready, busy);
        end
        finish_handshake();
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            failures++;
            $display("FAIL first_release: got valid/busy/ready=%b required 001",
                     {out_valid, busy, in_ready});
        end
    endtask

    task automatic test_last_entry();
        int lat;
        accept_and_wait(24'hFFFFC0, lat);
        checks++;
        if (rom_addr !== 6'd63) begin
            failures++;
            $display("FAIL last_rom_addr: got %0d required 63", rom_addr);
        end
        checks++;
        if (out_y !== 20'h0061E || lat !== 4) begin
            failures++;
            $display("FAIL last_out_y: got %h lat=%0d required 0061e lat=4", out_y, lat);
        end
        finish_handshake();
    endtask

    task automatic test_hold_done();
        int lat;
        // Entry 2, frac 3 -> y = 2 + 2*3 = 8.
        accept_and_wait(24'h0800C0, lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_x     = 24'h0C0000 + 24'(i * 64);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, busy, rom_addr, out_y} !==
                {1'b1, 1'b0, 1'b1, 6'd2, 20'h00008}) begin
                failures++;
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b busy=%b addr=%0d y=%h required 1/0/1/2/00008",
                         i, out_valid, in_ready, busy, rom_addr, out_y);
            end
        end
        // Entry 3, frac 1 -> y = 3 + 3 = 6; held valid across the handshake.
        in_x      = 24'h0C0040;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL hold_release: got valid/ready/busy=%b required 010",
                     {out_valid, in_ready, busy});
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || rom_addr !== 6'd3) begin
            failures++;
            $display("FAIL hold_next_accept: got busy=%b addr=%0d required 1/3", busy, rom_addr);
        end
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (out_y !== 20'h00006 || lat !== 4) begin
            failures++;
            $display("FAIL hold_next_result: got %h lat=%0d required 00006 lat=4", out_y, lat);
        end
        finish_handshake();
    endtask

    task automatic test_reset_in_wait();
        int seen;
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 24'h100000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({in_ready, busy, out_valid, sat_flag, rom_addr, out_y} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 20'h0}) begin
            failures++;
            $display("FAIL wait_reset_state: got ready=%b busy=%b valid=%b sat=%b addr=%0d y=%h required 1/0/0/0/0/00000",
                     in_ready, busy, out_valid, sat_flag, rom_addr, out_y);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL wait_reset_drop: got %0d valid cycles required 0", seen);
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic [19:0] exp_y;
        logic        exp_sat;
`ifdef SQRT_SAT_EN
        exp_y   = 20'hFFFFF;
        exp_sat = 1'b1;
`else
        // 4095 + floor(0xFFFFF*0xFFF / 4096) = 1052414 -> mod 2^20 = 0x00EFE.
        exp_y   = 20'h00EFE;
        exp_sat = 1'b0;
`endif
        accept_and_wait(24'h17FFC0, lat);
        checks++;
        if (out_y !== exp_y || sat_flag !== exp_sat) begin
            failures++;
            $display("FAIL sat_result: got y=%h sat=%b required %h/%b", out_y, sat_flag, exp_y, exp_sat);
        end
        finish_handshake();
        accept_and_wait(24'h000000, lat);
        checks++;
        if (out_y !== 20'h0043F || sat_flag !== exp_sat) begin
            failures++;
            $display("FAIL sat_sticky: got y=%h sat=%b required 0043f/%b", out_y, sat_flag, exp_sat);
        end
        finish_handshake();
    endtask

    task automatic test_back_to_back_lat3();
        int n, lat1, lat2;
        logic got1;
        logic [19:0] y1, y2;
        got1 = 1'b0;
        y1   = '0;
        lat1 = 0;
        // Entry 10, frac 0x100 -> 10 + 2560 = 0xA0A; entry 11, frac 0x010 -> 0xBB.
        @(negedge clk);
        in_valid3  = 1'b1;
        in_x3      = 24'h284000;
        out_ready3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_x3 = 24'h2C0400;
        n = 0;
        while (n < 30) begin
            if (out_valid3 === 1'b1 && !got1) begin
                y1   = out_y3;
                lat1 = n + 1;
                got1 = 1'b1;
            end
            if (in_ready3 === 1'b1) break;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checks++;
        if (y1 !== 20'h00A0A || lat1 !== 6) begin
            failures++;
            $display("FAIL lat3_first: got y=%h lat=%0d required 00a0a lat=6", y1, lat1);
        end
        checks++;
        if (n + 1 !== 7) begin
            failures++;
            $display("FAIL lat3_spacing: got %0d required 7", n + 1);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid3 = 1'b0;
        lat2 = 1;
        while (out_valid3 !== 1'b1 && lat2 < 40) begin
            @(posedge clk);
            lat2++;
            @(negedge clk);
        end
        y2 = out_y3;
        checks++;
        if (y2 !== 20'h000BB || lat2 !== 6) begin
            failures++;
            $display("FAIL lat3_second: got y=%h lat=%0d required 000bb lat=6", y2, lat2);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready3 = 1'b0;
        checks++;
        if ({out_valid3, busy3, in_ready3, rom_addr3} !== {3'b001, 6'd11}) begin
            failures++;
            $display("FAIL lat3_idle: got valid/busy/ready=%b addr=%0d required 001/11",
                     {out_valid3, busy3, in_ready3}, rom_addr3);
        end
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_x       = '0;
        out_ready  = 1'b0;
        in_valid3  = 1'b0;
        in_x3      = '0;
        out_ready3 = 1'b0;
        test_reset();
        test_first_entry();
        test_last_entry();
        test_hold_done();
        test_reset_in_wait();
        test_saturation();
        test_back_to_back_lat3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
